boot_image_loader: RTL and testbench

- Bootstrap sequencer directly downstream of the SPI microSD reader.
- Requests consecutive 32-bit words from the SD reader and validates an image header (magic and length).
- Copies the payload into program memory and verifies a trailing checksum.
- Holds the CPU in reset until a valid image has been loaded; on any failure, reports an error code and keeps the CPU in reset.

---
 rtl/boot_image_loader_pkg.sv | 48 ++++
 rtl/boot_image_loader_if.sv | 30 +++
 rtl/boot_image_loader_timeout_counter.sv | 39 +++
 rtl/boot_image_loader.sv | 202 ++++++++++++++++++++
 tb/tb_boot_image_loader.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/boot_image_loader_pkg.sv
// ---------------------------------------------------------------------------
// boot_loader_pkg
// Shared definitions for the boot image loader: FSM state encoding, error
// codes reported on err_o, the default image magic word and the layout of
// the image header on the SD card.
// ---------------------------------------------------------------------------
package boot_loader_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_RD_MAGIC = 3'd1;
   localparam logic [2:0] ST_RD_LEN   = 3'd2;
   localparam logic [2:0] ST_RD_DATA  = 3'd3;
   localparam logic [2:0] ST_RD_CSUM  = 3'd4;
   localparam logic [2:0] ST_DONE     = 3'd5;
   localparam logic [2:0] ST_ERROR    = 3'd6;

   typedef enum logic [2:0] {
      IDLE     = ST_IDLE,
      RD_MAGIC = ST_RD_MAGIC,
      RD_LEN   = ST_RD_LEN,
      RD_DATA  = ST_RD_DATA,
      RD_CSUM  = ST_RD_CSUM,
      DONE     = ST_DONE,
      ERROR    = ST_ERROR
   } state_t;

   localparam logic [2:0] ERR_NONE    = 3'b000;
   localparam logic [2:0] ERR_MAGIC   = 3'b001;
   localparam logic [2:0] ERR_LEN     = 3'b010;
   localparam logic [2:0] ERR_CSUM    = 3'b011;
   localparam logic [2:0] ERR_TIMEOUT = 3'b100;

   localparam logic [31:0] DEFAULT_MAGIC = 32'h424F_4F54;

   // Image layout in 32-bit words relative to the SD base address:
   // magic, length N, N payload words, then the checksum word.
   localparam int HDR_MAGIC_WORD = 0;
   localparam int HDR_LEN_WORD   = 1;
   localparam int HDR_DATA_WORD  = 2;

   localparam logic [31:0] WORD_BYTES = 32'd4;

   // States in which one SD read is outstanding and sd_valid_i is accepted.
   function automatic logic isReadState(input state_t s);
      return (s == RD_MAGIC) || (s == RD_LEN) || (s == RD_DATA) || (s == RD_CSUM);
   endfunction

endpackage

// File: rtl/boot_image_loader_if.sv
// ---------------------------------------------------------------------------
// boot_image_loader_if
// Bundles the SD-reader request/response signals and the program-memory
// write port of the boot loader.
//   master : the loader (drives the SD request and the memory write port)
//   slave  : the SD reader / memory side (returns sd_valid_i / sd_data_i)
// ---------------------------------------------------------------------------
interface boot_image_loader_if #(
   parameter int MEM_AW = 12
);

   logic [31:0]       sd_address_o;
   logic              sd_re_o;
   logic              sd_valid_i;
   logic [31:0]       sd_data_i;
   logic [MEM_AW-1:0] mem_addr_o;
   logic [31:0]       mem_data_o;
   logic              mem_we_o;

   modport master (
      output sd_address_o, sd_re_o, mem_addr_o, mem_data_o, mem_we_o,
      input  sd_valid_i, sd_data_i
   );

   modport slave (
      input  sd_address_o, sd_re_o, mem_addr_o, mem_data_o, mem_we_o,
      output sd_valid_i, sd_data_i
   );

endinterface

// File: rtl/boot_image_loader_timeout_counter.sv
// ---------------------------------------------------------------------------
// boot_timeout_counter
// Counts cycles spent waiting for an SD response.
//   clk, rst   : clock, asynchronous active-high reset
//   i_clear    : restart the count (asserted together with a new read request)
//   i_enable   : a read is outstanding, count this cycle
//   o_expired  : this is the TIMEOUT_CYC-th waiting cycle since the request
// ---------------------------------------------------------------------------
module boot_timeout_counter #(
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] r_count;

   // The count is zero in the cycle the request is visible, so the value
   // LAST marks the TIMEOUT_CYC-th cycle of waiting. It saturates there so
   // a lingering enable can never wrap around to a fresh window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != LAST)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expired = i_enable && !i_clear && (r_count == LAST);

endmodule

// File: rtl/boot_image_loader.sv
// ---------------------------------------------------------------------------
// boot_image_loader
// Bootstrap sequencer behind the SPI microSD reader. Reads the image header
// (magic, length), copies the payload into program memory, verifies the
// trailing 32-bit additive checksum and only then releases the CPU reset.
//   control_clk_i / control_rst_i : clock, asynchronous active-high reset
//   start_i    : one-cycle pulse starting (or restarting) a boot
//   bus        : SD request/response and program-memory write port
//   cpu_rst_o  : CPU reset hold, low only after a verified image
//   busy_o     : load in progress
//   done_o     : image loaded and verified
//   err_o      : 000 none, 001 magic, 010 length, 011 checksum, 100 timeout
// ---------------------------------------------------------------------------
module boot_image_loader
   import boot_loader_pkg::*;
#(
   parameter int          MEM_AW       = 12,
   parameter logic [31:0] BASE_SD_ADDR = 32'h0000_0000,
   parameter logic [31:0] MAGIC        = DEFAULT_MAGIC,
   parameter int          TIMEOUT_CYC  = 1_000_000
) (
   input  logic                 control_clk_i,
   input  logic                 control_rst_i,
   input  logic                 start_i,
   boot_image_loader_if.master  bus,
   output logic                 cpu_rst_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [2:0]           err_o
);

   localparam logic [31:0] MAX_LEN = 32'd1 << MEM_AW;

   state_t            r_state;
   state_t            w_nextState;
   logic [31:0]       r_sdAddr;
   logic              r_sdRe;
   logic [MEM_AW-1:0] r_memAddr;
   logic [31:0]       r_memData;
   logic              r_memWe;
   logic [2:0]        r_err;
   logic [MEM_AW:0]   r_wordCnt;
   logic [MEM_AW:0]   r_len;
   logic [31:0]       r_sum;

   logic              w_inRead;
   logic              w_accept;
   logic              w_start;
   logic              w_expired;
   logic              w_issueRe;
   logic              w_errSet;
   logic [2:0]        w_errCode;
   logic              w_lenBad;
   logic              w_lastWord;

   assign w_inRead   = isReadState(r_state);
   assign w_accept   = w_inRead && bus.sd_valid_i;
   assign w_start    = start_i && !w_inRead;
   assign w_lenBad   = (bus.sd_data_i == 32'd0) || (bus.sd_data_i > MAX_LEN);
   assign w_lastWord = ((r_wordCnt + 1'b1) == r_len);

   boot_timeout_counter #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk       (control_clk_i),
      .rst       (control_rst_i),
      .i_clear   (w_issueRe),
      .i_enable  (w_inRead),
      .o_expired (w_expired)
   );

   // State register; reset lands in IDLE immediately.
   always_ff @(posedge control_clk_i or posedge control_rst_i) begin
      if (control_rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. Every move into a read state (including the repeat
   // of RD_DATA for the next payload word) raises w_issueRe, which becomes
   // the one-cycle sd_re_o pulse and restarts the timeout window. A word
   // accepted in the same cycle the timeout expires takes priority.
   always_comb begin
      w_nextState = r_state;
      w_issueRe   = 1'b0;
      w_errSet    = 1'b0;
      w_errCode   = ERR_NONE;
      case (r_state)
         IDLE, DONE, ERROR: begin
            if (start_i) begin
               w_nextState = RD_MAGIC;
               w_issueRe   = 1'b1;
            end
         end
         RD_MAGIC: begin
            if (w_accept) begin
               if (bus.sd_data_i != MAGIC) begin
                  w_nextState = ERROR;
                  w_errSet    = 1'b1;
                  w_errCode   = ERR_MAGIC;
               end else begin
                  w_nextState = RD_LEN;
                  w_issueRe   = 1'b1;
               end
            end
         end
         RD_LEN: begin
            if (w_accept) begin
               if (w_lenBad) begin
                  w_nextState = ERROR;
                  w_errSet    = 1'b1;
                  w_errCode   = ERR_LEN;
               end else begin
                  w_nextState = RD_DATA;
                  w_issueRe   = 1'b1;
               end
            end
         end
         RD_DATA: begin
            if (w_accept) begin
               w_nextState = w_lastWord ? RD_CSUM : RD_DATA;
               w_issueRe   = 1'b1;
            end
         end
         RD_CSUM: begin
            if (w_accept) begin
               if (bus.sd_data_i == r_sum) begin
                  w_nextState = DONE;
               end else begin
                  w_nextState = ERROR;
                  w_errSet    = 1'b1;
                  w_errCode   = ERR_CSUM;
               end
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
      if (w_inRead && !w_accept && w_expired) begin
         w_nextState = ERROR;
         w_issueRe   = 1'b0;
         w_errSet    = 1'b1;
         w_errCode   = ERR_TIMEOUT;
      end
   end

   // Datapath: SD address walk, word counter, checksum and the memory write
   // port. mem_we_o is a one-cycle pulse in the cycle after each payload
   // word arrives, carrying that word and its index.
   always_ff @(posedge control_clk_i or posedge control_rst_i) begin
      if (control_rst_i) begin
         r_sdAddr  <= BASE_SD_ADDR;
         r_sdRe    <= 1'b0;
         r_memAddr <= '0;
         r_memData <= '0;
         r_memWe   <= 1'b0;
         r_err     <= ERR_NONE;
         r_wordCnt <= '0;
         r_len     <= '0;
         r_sum     <= '0;
      end else begin
         r_sdRe  <= w_issueRe;
         r_memWe <= 1'b0;
         if (w_start) begin
            r_sdAddr  <= BASE_SD_ADDR;
            r_wordCnt <= '0;
            r_sum     <= '0;
            r_err     <= ERR_NONE;
         end else if (w_accept) begin
            r_sdAddr <= r_sdAddr + WORD_BYTES;
         end
         if (w_accept && (r_state == RD_LEN)) begin
            r_len <= bus.sd_data_i[MEM_AW:0];
         end
         if (w_accept && (r_state == RD_DATA)) begin
            r_memWe   <= 1'b1;
            r_memAddr <= r_wordCnt[MEM_AW-1:0];
            r_memData <= bus.sd_data_i;
            r_sum     <= r_sum + bus.sd_data_i;
            r_wordCnt <= r_wordCnt + 1'b1;
         end
         if (w_errSet) begin
            r_err <= w_errCode;
         end
      end
   end

   assign bus.sd_address_o = r_sdAddr;
   assign bus.sd_re_o      = r_sdRe;
   assign bus.mem_addr_o   = r_memAddr;
   assign bus.mem_data_o   = r_memData;
   assign bus.mem_we_o     = r_memWe;

   assign busy_o    = w_inRead;
   assign done_o    = (r_state == DONE);
   assign cpu_rst_o = (r_state != DONE);
   assign err_o     = r_err;

endmodule

// File: tb/tb_boot_image_loader.sv
// ---------------------------------------------------------------------------
// tb_boot_image_loader
// Drives boot_image_loader with an SD-card image held in an array and
// compares the SD read sequence, memory writes and final status against an
// image-level model of the boot rules.
// ---------------------------------------------------------------------------
module tb_boot_image_loader;
   import boot_loader_pkg::*;

   localparam int          MEM_AW = 12;
   localparam int          TCYC   = 16;
   localparam logic [31:0] TMAGIC = 32'h424F_4F54;
   localparam int          IMG_WORDS = 4200;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       cpuRst;
   logic       busy;
   logic       done;
   logic [2:0] err;

   boot_image_loader_if #(.MEM_AW(MEM_AW)) bus ();

   boot_image_loader #(
      .MEM_AW       (MEM_AW),
      .BASE_SD_ADDR (32'h0000_0000),
      .MAGIC        (TMAGIC),
      .TIMEOUT_CYC  (TCYC)
   ) dut (
      .control_clk_i (clk),
      .control_rst_i (rst),
      .start_i       (start),
      .bus           (bus),
      .cpu_rst_o     (cpuRst),
      .busy_o        (busy),
      .done_o        (done),
      .err_o         (err)
   );

   always #5 clk = ~clk;

   int                compared = 0;
   int                mismatched = 0;
   longint            cyc = 0;
   longint            firstReCyc = 0;
   logic [31:0]       img [0:IMG_WORDS-1];
   logic [31:0]       reQ [$];
   logic [MEM_AW-1:0] wrAQ [$];
   logic [31:0]       wrDQ [$];
   bit                respondEn = 1'b1;
   int                forceLat = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every read request address and every memory write.
   always @(negedge clk) begin
      if (bus.sd_re_o === 1'b1) begin
         if (reQ.size() == 0) firstReCyc = cyc;
         reQ.push_back(bus.sd_address_o);
      end
      if (bus.mem_we_o === 1'b1) begin
         wrAQ.push_back(bus.mem_addr_o);
         wrDQ.push_back(bus.mem_data_o);
      end
   end

   // SD reader model: answers each request after forceLat cycles, or a
   // random 1..6 cycles, with the image word at the requested address.
   initial begin
      logic [31:0] a;
      int          lat;
      bus.sd_valid_i = 1'b0;
      bus.sd_data_i  = 32'd0;
      forever begin
         @(negedge clk);
         bus.sd_valid_i = 1'b0;
         if (bus.sd_re_o === 1'b1 && respondEn && !rst) begin
            a   = bus.sd_address_o;
            lat = (forceLat > 0) ? forceLat : int'($urandom_range(1, 6));
            repeat (lat - 1) @(negedge clk);
            bus.sd_data_i  = ((a >> 2) < IMG_WORDS) ? img[a >> 2] : 32'd0;
            bus.sd_valid_i = 1'b1;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkReset(input string tag);
      check({tag, " sd_address"}, 64'(bus.sd_address_o), 64'h0);
      check({tag, " sd_re"},      64'(bus.sd_re_o), 64'h0);
      check({tag, " mem_addr"},   64'(bus.mem_addr_o), 64'h0);
      check({tag, " mem_data"},   64'(bus.mem_data_o), 64'h0);
      check({tag, " mem_we"},     64'(bus.mem_we_o), 64'h0);
      check({tag, " cpu_rst"},    64'(cpuRst), 64'h1);
      check({tag, " busy"},       64'(busy), 64'h0);
      check({tag, " done"},       64'(done), 64'h0);
      check({tag, " err"},        64'(err), 64'h0);
   endtask

   task automatic applyStimulus(input bit glitch, output longint endCyc, output bit timedOut);
      reQ.delete();
      wrAQ.delete();
      wrDQ.delete();
      endCyc   = 0;
      timedOut = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (glitch) begin
         @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (done === 1'b1 || (err !== 3'b000)) begin
            timedOut = 1'b0;
            endCyc   = cyc;
            break;
         end
      end
      repeat (3) @(negedge clk);
   endtask

   // Model: derive the expected outcome from the image contents alone.
   task automatic checkOutput(input string tag, input bit timedOut, input bit expTimeout, input longint endCyc);
      int          expErr;
      int          nReads;
      int          nWrites;
      logic [31:0] n;
      logic [31:0] sum;
      n   = img[HDR_LEN_WORD];
      sum = 32'd0;
      nWrites = 0;
      if (expTimeout) begin
         expErr = 4; nReads = 1;
      end else if (img[HDR_MAGIC_WORD] !== TMAGIC) begin
         expErr = 1; nReads = 1;
      end else if (n == 32'd0 || n > (32'd1 << MEM_AW)) begin
         expErr = 2; nReads = 2;
      end else begin
         for (int i = 0; i < int'(n); i++) sum = sum + img[HDR_DATA_WORD + i];
         nWrites = int'(n);
         nReads  = int'(n) + 3;
         expErr  = (img[HDR_DATA_WORD + int'(n)] == sum) ? 0 : 3;
      end
      check({tag, " completion"}, 64'(timedOut), 64'h0);
      check({tag, " err"},     64'(err), 64'(expErr));
      check({tag, " done"},    64'(done), 64'(expErr == 0));
      check({tag, " cpu_rst"}, 64'(cpuRst), 64'(expErr != 0));
      check({tag, " busy"},    64'(busy), 64'h0);
      check({tag, " reads"},   64'(reQ.size()), 64'(nReads));
      for (int i = 0; i < reQ.size() && i < nReads; i++)
         check($sformatf("%s sd_addr[%0d]", tag, i), 64'(reQ[i]), 64'(4 * i));
      check({tag, " writes"},  64'(wrAQ.size()), 64'(nWrites));
      for (int i = 0; i < wrAQ.size() && i < nWrites; i++) begin
         check($sformatf("%s wr_addr[%0d]", tag, i), 64'(wrAQ[i]), 64'(i));
         check($sformatf("%s wr_data[%0d]", tag, i), 64'(wrDQ[i]), 64'(img[HDR_DATA_WORD + i]));
      end
      if (expTimeout)
         check({tag, " timeout cycles"}, 64'(endCyc - firstReCyc), 64'(TCYC));
   endtask

   task automatic setScenario1();
      img[0] = TMAGIC;
      img[1] = 32'd4;
      for (int i = 0; i < 4; i++) img[2 + i] = 32'(i + 1);
      img[6] = 32'd10;
   endtask

   initial begin
      longint      endCyc;
      bit          timedOut;
      bit          found;
      int          kind;
      int          n;
      logic [31:0] sum;

      repeat (3) @(negedge clk);
      checkReset("por");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] scenario 1: N=4 good image");
      setScenario1();
      applyStimulus(1'b0, endCyc, timedOut);
      checkOutput("good4", timedOut, 1'b0, endCyc);

      $display("[TB] bad magic");
      img[0] = 32'hDEAD_BEEF;
      applyStimulus(1'b0, endCyc, timedOut);
      checkOutput("magic", timedOut, 1'b0, endCyc);

      $display("[TB] length 0 and length 4097");
      img[0] = TMAGIC;
      img[1] = 32'd0;
      applyStimulus(1'b0, endCyc, timedOut);
      checkOutput("len0", timedOut, 1'b0, endCyc);
      img[1] = 32'd4097;
      applyStimulus(1'b0, endCyc, timedOut);
      checkOutput("len4097", timedOut, 1'b0, endCyc);

      $display("[TB] checksum error");
      img[1] = 32'd3; img[2] = 32'd5; img[3] = 32'd6; img[4] = 32'd7; img[5] = 32'd17;
      applyStimulus(1'b0, endCyc, timedOut);
      checkOutput("csum", timedOut, 1'b0, endCyc);

      $display("[TB] timeout with no response");
      setScenario1();
      respondEn = 1'b0;
      applyStimulus(1'b0, endCyc, timedOut);
      checkOutput("timeout", timedOut, 1'b1, endCyc);
      respondEn = 1'b1;

      $display("[TB] response on the last cycle of the timeout window");
      forceLat = TCYC;
      applyStimulus(1'b0, endCyc, timedOut);
      checkOutput("lateValid", timedOut, 1'b0, endCyc);
      forceLat = 0;

      $display("[TB] asynchronous reset during data word 2");
      forceLat = 2;
      reQ.delete(); wrAQ.delete(); wrDQ.delete();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.mem_we_o === 1'b1 && bus.mem_addr_o == 12'd1) begin
            found = 1'b1;
            break;
         end
      end
      check("rstWindow found", 64'(found), 64'h1);
      #1 rst = 1'b1;
      #1 checkReset("asyncRst");
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      forceLat = 0;
      applyStimulus(1'b0, endCyc, timedOut);
      checkOutput("afterRst", timedOut, 1'b0, endCyc);

      $display("[TB] maximum length image");
      forceLat = 1;
      img[0] = TMAGIC;
      img[1] = 32'd4096;
      sum = 32'd0;
      for (int i = 0; i < 4096; i++) begin
         img[2 + i] = $urandom;
         sum = sum + img[2 + i];
      end
      img[4098] = sum;
      applyStimulus(1'b0, endCyc, timedOut);
      checkOutput("max", timedOut, 1'b0, endCyc);
      forceLat = 0;

      $display("[TB] randomized images");
      for (int k = 0; k < 8; k++) begin
         kind = int'($urandom_range(0, 4));
         n    = int'($urandom_range(1, 12));
         img[0] = TMAGIC;
         img[1] = 32'(n);
         sum = 32'd0;
         for (int i = 0; i < n; i++) begin
            img[2 + i] = $urandom;
            sum = sum + img[2 + i];
         end
         img[2 + n] = sum;
         if (kind == 1) img[2 + n] = sum ^ (32'd1 << $urandom_range(0, 31));
         if (kind == 2) begin
            img[0] = $urandom;
            if (img[0] == TMAGIC) img[0] = img[0] ^ 32'd1;
         end
         if (kind == 3) img[1] = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'd4097 + $urandom_range(0, 1000);
         applyStimulus((kind == 0) || (kind == 1) || (kind == 4), endCyc, timedOut);
         checkOutput($sformatf("rand%0d", k), timedOut, 1'b0, endCyc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
